// File: rtl/alu8_seq.sv
// alu8_seq: 8-bit ALU with single-cycle logic/arith ops and iterative multiply/shift,
// completing with a one-cycle WRITE_EN strobe toward the register-file write port.
module alu8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       DEST,
    output logic [WIDTH-1:0] RESULT,
    output logic [2:0]       RESULT_ADDR,
    output logic             WRITE_EN,
    output logic             ZERO,
    output logic             CARRY
);
    localparam logic [2:0] OP_FWD = 3'd0, OP_ADD = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_SUB = 3'd4, OP_MUL = 3'd5, OP_SLL = 3'd6, OP_SRA = 3'd7;
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [2:0]         op, dst;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_step;
    logic [WIDTH-1:0]   mplier, sr, sr_step, sc_r, fin_r;
    logic [WIDTH:0]     sum, diff;
    logic [2:0]         amt;
    logic               accept, multi, last, sc_c, sr_c, fin_c;
    assign ready  = state == IDLE;
    assign accept = start && ready;
    assign amt    = DATA2[2:0];
    assign multi  = SELECT == OP_MUL || ((SELECT == OP_SLL || SELECT == OP_SRA) && amt != 3'd0);
    assign last   = cnt == CW'(1);
    assign sum    = {1'b0, DATA1} + {1'b0, DATA2};
    assign diff   = {1'b0, DATA1} - {1'b0, DATA2};
    always_comb begin
        sc_r = DATA1;
        sc_c = 1'b0;
        case (SELECT)
            OP_FWD:  sc_r = DATA2;
            OP_ADD:  {sc_c, sc_r} = sum;
            OP_AND:  sc_r = DATA1 & DATA2;
            OP_OR:   sc_r = DATA1 | DATA2;
            OP_SUB:  {sc_c, sc_r} = diff;
            default: sc_r = DATA1;
        endcase
    end
    // One iteration of shift-add multiply and single-bit shift; final step result is written out.
    always_comb begin
        acc_step = mplier[0] ? acc + mcand : acc;
        sr_step  = op == OP_SLL ? sr << 1 : {sr[WIDTH-1], sr[WIDTH-1:1]};
        sr_c     = op == OP_SLL ? sr[WIDTH-1] : sr[0];
        fin_r    = op == OP_MUL ? acc_step[WIDTH-1:0] : sr_step;
        fin_c    = op == OP_MUL ? |acc_step[2*WIDTH-1:WIDTH] : sr_c;
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept && multi)
            state_nx = BUSY;
        else if (state == BUSY && last)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            op          <= '0;
            dst         <= '0;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            sr          <= '0;
            RESULT      <= '0;
            RESULT_ADDR <= '0;
            WRITE_EN    <= 1'b0;
            ZERO        <= 1'b0;
            CARRY       <= 1'b0;
        end else begin
            WRITE_EN <= 1'b0;
            if (accept) begin
                op     <= SELECT;
                dst    <= DEST;
                cnt    <= SELECT == OP_MUL ? CW'(WIDTH) : CW'(amt);
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, DATA1};
                mplier <= DATA2;
                sr     <= DATA1;
                if (!multi) begin
                    RESULT      <= sc_r;
                    CARRY       <= sc_c;
                    ZERO        <= sc_r == '0;
                    RESULT_ADDR <= DEST;
                    WRITE_EN    <= 1'b1;
                end
            end else if (state == BUSY) begin
                cnt    <= cnt - CW'(1);
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                sr     <= sr_step;
                if (last) begin
                    RESULT      <= fin_r;
                    CARRY       <= fin_c;
                    ZERO        <= fin_r == '0;
                    RESULT_ADDR <= dst;
                    WRITE_EN    <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_alu8_seq.sv
// tb_alu8_seq: directed and randomized checks of alu8_seq against an arithmetic reference model.
module tb_alu8_seq;
    logic       clk = 1'b0;
    logic       reset, start, ready, WRITE_EN, ZERO, CARRY;
    logic [2:0] SELECT, DEST, RESULT_ADDR;
    logic [7:0] DATA1, DATA2, RESULT;
    int         checks = 0;
    int         errors = 0;
    alu8_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .DEST(DEST), .RESULT(RESULT),
        .RESULT_ADDR(RESULT_ADDR), .WRITE_EN(WRITE_EN), .ZERO(ZERO), .CARRY(CARRY)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic void model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output int lat);
        int n = int'(b[2:0]);
        int p = 0;
        c = 1'b0;
        lat = 0;
        case (s)
            3'd0: r = b;
            3'd1: begin p = int'(a) + int'(b); r = p[7:0]; c = p > 255; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin r = a - b; c = a < b; end
            3'd5: begin p = int'(a) * int'(b); r = p[7:0]; c = p > 255; lat = 8; end
            3'd6: begin r = a << n; c = n > 0 ? a[8 - n] : 1'b0; lat = n; end
            default: begin r = 8'($signed(a) >>> n); c = n > 0 ? a[n - 1] : 1'b0; lat = n; end
        endcase
    endfunction
    task automatic do_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] d, input bit noise);
        logic [7:0] er;
        logic       ec;
        int         lat;
        int         k = 0;
        model(s, a, b, er, ec, lat);
        @(negedge clk);
        start = 1'b1; SELECT = s; DATA1 = a; DATA2 = b; DEST = d;
        chk("ready_idle", ready, 1);
        @(posedge clk); #1;
        start = 1'b0;
        while (!WRITE_EN && k < 20) begin
            if (k < lat) chk("ready_busy", ready, 0);
            start = noise && k < lat;
            SELECT = 3'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom); DEST = 3'($urandom);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("latency", k, lat);
        chk("result", RESULT, er);
        chk("carry", CARRY, ec);
        chk("zero", ZERO, er == 8'd0);
        chk("addr", RESULT_ADDR, d);
        @(posedge clk); #1;
        chk("we_pulse", WRITE_EN, 0);
    endtask
    logic [2:0] b_sel [3] = '{3'd1, 3'd4, 3'd4};
    logic [7:0] b_a   [3] = '{8'd200, 8'd5, 8'd9};
    logic [7:0] b_b   [3] = '{8'd100, 8'd7, 8'd9};
    initial begin
        logic [7:0] er;
        logic       ec;
        int         lat;
        bit         we_seen;
        reset = 1'b1; start = 1'b1; SELECT = 3'd1; DATA1 = 8'd3; DATA2 = 8'd4; DEST = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", RESULT, 0);
        chk("rst_we", WRITE_EN, 0);
        chk("rst_zero", ZERO, 0);
        chk("rst_carry", CARRY, 0);
        chk("rst_ready", ready, 1);
        chk("rst_addr", RESULT_ADDR, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        do_op(3'd0, 8'd1, 8'h3C, 3'd5, 0);
        chk("fwd_val", RESULT, 8'h3C);
        // Back-to-back single-cycle ops with start held high.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; SELECT = b_sel[i]; DATA1 = b_a[i]; DATA2 = b_b[i]; DEST = 3'(i + 1);
            model(b_sel[i], b_a[i], b_b[i], er, ec, lat);
            @(posedge clk); #1;
            chk("b2b_we", WRITE_EN, 1);
            chk("b2b_result", RESULT, er);
            chk("b2b_carry", CARRY, ec);
            chk("b2b_zero", ZERO, er == 8'd0);
            chk("b2b_addr", RESULT_ADDR, i + 1);
        end
        start = 1'b0;
        chk("sub_zero_flag", ZERO, 1);
        @(posedge clk); #1;
        chk("b2b_we_end", WRITE_EN, 0);
        do_op(3'd5, 8'd13, 8'd11, 3'd2, 1);
        chk("mul_143", RESULT, 143);
        do_op(3'd5, 8'd20, 8'd20, 3'd7, 1);
        chk("mul_ovf", CARRY, 1);
        do_op(3'd7, 8'h90, 8'd3, 3'd1, 1);
        chk("sra_val", RESULT, 8'hF2);
        do_op(3'd6, 8'h81, 8'd1, 3'd4, 0);
        chk("sll_val", RESULT, 8'h02);
        do_op(3'd6, 8'h5A, 8'h08, 3'd0, 0);
        chk("sll0_val", RESULT, 8'h5A);
        do_op(3'd5, 8'd7, 8'd9, 3'd3, 0);
        chk("mul_63", RESULT, 63);
        for (int i = 0; i < 40; i++)
            do_op(3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; SELECT = 3'd5; DATA1 = 8'd255; DATA2 = 8'd255; DEST = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_result", RESULT, 0);
        chk("arst_ready", ready, 1);
        chk("arst_we", WRITE_EN, 0);
        chk("arst_addr", RESULT_ADDR, 0);
        @(negedge clk);
        reset = 1'b0;
        we_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            we_seen |= WRITE_EN;
        end
        chk("arst_no_we", we_seen, 0);
        do_op(3'd1, 8'd1, 8'd1, 3'd2, 0);
        chk("post_rst_add", RESULT, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
